seg7_scan_capture: RTL and testbench

- Receive-side counterpart of the 8-digit multiplexed seven-segment driver.
- Watches the active-low digit-enable (AN) and active-low segment buses, and decodes each settled digit back to a hex nibble.
- Reassembles complete scan frames into the 32-bit value being displayed.
- Used to mirror the display into a readable register and as a self-check monitor on the display path.

---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/seg7_scan_capture_if.sv | 9 +
 rtl/seg7_decode.sv | 38 +++
 rtl/seg7_scan_capture.sv | 190 +++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan capture block: active-low
// segment patterns, FSM state encoding, error flag positions and the
// decoded-digit record.
package seg7_pkg;

    // Active-low segment patterns, segments a..g on bits 6..0.
    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4f;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4c;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0f;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h60;
    localparam logic [6:0] SEG_C     = 7'h31;
    localparam logic [6:0] SEG_D     = 7'h42;
    localparam logic [6:0] SEG_E     = 7'h30;
    localparam logic [6:0] SEG_F     = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7f;

    // Frame tracker: HUNT waits for digit 0, COLLECT assembles digits 1..7.
    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Bit positions inside err_flags.
    localparam int ERR_SEG     = 0;
    localparam int ERR_AN      = 1;
    localparam int ERR_ORDER   = 2;
    localparam int ERR_TIMEOUT = 3;

    // Result of decoding one segment pattern.
    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Multiplexed display bus as seen on the wire: active-low digit enables and
// active-low segments. The display driver owns it, the capture block listens.
interface seg7_scan_capture_if;
    logic [7:0] an_in;
    logic [6:0] seg_in;

    modport master (output an_in, output seg_in);
    modport slave  (input  an_in, input  seg_in);
endinterface

// File: rtl/seg7_decode.sv
// Combinational inverse of the hex-to-seven-segment table. Blank (all
// segments off) decodes as a valid nibble 0 with the blank bit set; any
// pattern outside the table is reported as invalid.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output seg_dec_t   dec
);

    // Pattern lookup against the hex table.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        dec = '{valid: 1'b1, blank: 1'b0, nibble: 4'h0};
        case (seg)
            SEG_0:     dec.nibble = 4'h0;
            SEG_1:     dec.nibble = 4'h1;
            SEG_2:     dec.nibble = 4'h2;
            SEG_3:     dec.nibble = 4'h3;
            SEG_4:     dec.nibble = 4'h4;
            SEG_5:     dec.nibble = 4'h5;
            SEG_6:     dec.nibble = 4'h6;
            SEG_7:     dec.nibble = 4'h7;
            SEG_8:     dec.nibble = 4'h8;
            SEG_9:     dec.nibble = 4'h9;
            SEG_A:     dec.nibble = 4'ha;
            SEG_B:     dec.nibble = 4'hb;
            SEG_C:     dec.nibble = 4'hc;
            SEG_D:     dec.nibble = 4'hd;
            SEG_E:     dec.nibble = 4'he;
            SEG_F:     dec.nibble = 4'hf;
            SEG_BLANK: dec.blank  = 1'b1;
            default:   dec.valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive-side monitor for an 8-digit multiplexed seven-segment display.
// Registers the bus, waits for each digit to settle, decodes it and
// reassembles complete 0..7 scans into dis_num / blank_mask.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_capture_if.slave  disp,
    input  logic                err_clr,
    output logic [31:0]         dis_num,
    output logic [7:0]          blank_mask,
    output logic                frame_valid,
    output logic                locked,
    output logic [3:0]          err_flags
);

    localparam int              TCNT_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]      SETTLE_LAST  = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]      SETTLE_MAX   = 8'(SETTLE_CYC);
    localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TIMEOUT_CYC - 1);

    logic [7:0]        an_q, an_prev;
    logic [6:0]        seg_q, seg_prev;
    logic [7:0]        settle_cnt;
    logic              changed, cap;

    logic [2:0]        idx;
    logic              an_multi;
    seg_dec_t          dec;

    state_t            state_q, state_d;
    logic [2:0]        exp_q, exp_d;
    logic [7:0]        seen_q, seen_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [7:0]        bshadow_q, bshadow_d;
    logic              done_q, done_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [3:0]        err_set;
    logic              load;

    // Input register plus a copy of the previous sample for change detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (rst) begin
            an_q     <= '0;
            seg_q    <= '0;
            an_prev  <= '0;
            seg_prev <= '0;
        end else begin
            an_q     <= disp.an_in;
            seg_q    <= disp.seg_in;
            an_prev  <= an_q;
            seg_prev <= seg_q;
        end
    end

    assign changed = {an_q, seg_q} != {an_prev, seg_prev};
    // Strobe on the cycle the counter steps onto SETTLE_CYC: once per window.
    assign cap     = !changed && (settle_cnt == SETTLE_LAST);

    // Settle counter: restarts on any bus change, saturates at SETTLE_CYC.
    always_ff @(posedge clk) begin
        if (rst || changed) begin
            settle_cnt <= '0;
        end else if (settle_cnt != SETTLE_MAX) begin
            settle_cnt <= settle_cnt + 8'd1;
        end
    end

    // Active digit index and detection of more than one enabled digit.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an_q[i]) idx = 3'(i);
        end
        an_multi = ((~an_q) & ((~an_q) - 8'd1)) != 8'd0;
    end

    seg7_decode u_decode (
        .seg (seg_q),
        .dec (dec)
    );

    // Frame tracker next-state: classifies each capture and assembles the shadow.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        seen_d    = seen_q;
        shadow_d  = shadow_q;
        bshadow_d = bshadow_q;
        done_d    = 1'b0;
        err_set   = '0;
        load      = 1'b0;
        tcnt_d    = (cap || state_q != COLLECT) ? '0 : tcnt_q + 1'b1;

        if (done_q) begin
            // Shadow now holds all eight digits: publish and rearm.
            load    = 1'b1;
            state_d = HUNT;
            seen_d  = '0;
        end else if (cap) begin
            if (an_q == 8'hff) begin
                // All digits off between dwells: nothing to capture.
            end else if (an_multi) begin
                err_set[ERR_AN] = 1'b1;
                state_d         = HUNT;
                seen_d          = '0;
            end else if (!dec.valid) begin
                err_set[ERR_SEG] = 1'b1;
                state_d          = HUNT;
                seen_d           = '0;
            end else if (state_q == HUNT) begin
                if (idx == 3'd0) begin
                    shadow_d[3:0] = dec.nibble;
                    bshadow_d[0]  = dec.blank;
                    seen_d        = 8'h01;
                    exp_d         = 3'd1;
                    state_d       = COLLECT;
                end
            end else if (idx == exp_q) begin
                shadow_d[{idx, 2'b00} +: 4] = dec.nibble;
                bshadow_d[idx]              = dec.blank;
                seen_d                      = seen_q | (8'h01 << idx);
                exp_d                       = exp_q + 3'd1;
                done_d                      = (idx == 3'd7) && ((seen_q | 8'h80) == 8'hff);
            end else if (idx == exp_q - 3'd1) begin
                // Segments changed during the same digit dwell: keep the newer value.
                shadow_d[{idx, 2'b00} +: 4] = dec.nibble;
                bshadow_d[idx]              = dec.blank;
            end else begin
                err_set[ERR_ORDER] = 1'b1;
                state_d            = HUNT;
                seen_d             = '0;
                if (idx == 3'd0) begin
                    shadow_d[3:0] = dec.nibble;
                    bshadow_d[0]  = dec.blank;
                    seen_d        = 8'h01;
                    exp_d         = 3'd1;
                    state_d       = COLLECT;
                end
            end
        end else if (state_q == COLLECT && tcnt_q == TCNT_LAST) begin
            err_set[ERR_TIMEOUT] = 1'b1;
            state_d              = HUNT;
            seen_d               = '0;
        end
    end

    // Frame tracker registers, published outputs and sticky error flags.
    always_ff @(posedge clk) begin
        // NOTE: the shadow is a handful of flops, not a RAM, so it is cleared
        // with everything else; a mid-frame reset must not leak stale digits.
        if (rst) begin
            state_q     <= HUNT;
            exp_q       <= '0;
            seen_q      <= '0;
            shadow_q    <= '0;
            bshadow_q   <= '0;
            done_q      <= 1'b0;
            tcnt_q      <= '0;
            dis_num     <= '0;
            blank_mask  <= '0;
            frame_valid <= 1'b0;
            err_flags   <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            seen_q      <= seen_d;
            shadow_q    <= shadow_d;
            bshadow_q   <= bshadow_d;
            done_q      <= done_d;
            tcnt_q      <= tcnt_d;
            frame_valid <= load;
            if (load) begin
                dis_num    <= shadow_q;
                blank_mask <= bshadow_q;
            end
            // A new error wins over a simultaneous clear.
            err_flags <= (err_clr ? 4'b0000 : err_flags) | err_set;
        end
    end

    assign locked = (state_q == COLLECT);

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture. Stimulus is a sequence of digit
// dwells on the display bus; a reference model processes each dwell as one
// capture event and tracks the expected frame, flags and lock state.
module tb_seg7_scan_capture;

    localparam int SETTLE = 4;
    localparam int TMO    = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_clr = 1'b0;
    logic [31:0] dis_num;
    logic [7:0]  blank_mask;
    logic        frame_valid;
    logic        locked;
    logic [3:0]  err_flags;

    seg7_scan_capture_if disp_if ();

    seg7_scan_capture #(
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .disp        (disp_if),
        .err_clr     (err_clr),
        .dis_num     (dis_num),
        .blank_mask  (blank_mask),
        .frame_valid (frame_valid),
        .locked      (locked),
        .err_flags   (err_flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fv_count = 0;
    int fv_cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Count frame_valid pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count = fv_count + 1;
            fv_cyc   = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0]  seg_tab [16] = '{7'h01, 7'h4f, 7'h12, 7'h06, 7'h4c, 7'h24, 7'h20, 7'h0f,
                                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    bit          m_lock;
    int          m_next;
    logic [31:0] m_shadow, m_num;
    logic [7:0]  m_bsh, m_blank;
    logic [3:0]  m_err;
    int          m_frames = 0;
    bit          m_have_prev;
    logic [7:0]  m_pan;
    logic [6:0]  m_pseg;

    task automatic model_reset();
        m_lock = 0; m_next = 0; m_shadow = '0; m_num = '0;
        m_bsh = '0; m_blank = '0; m_err = '0; m_have_prev = 0;
    endtask

    // Returns the hex value, 16 for blank, -1 for an unknown pattern.
    function automatic int seg_lookup(input logic [6:0] s);
        if (s == 7'h7f) return 16;
        for (int i = 0; i < 16; i++) if (seg_tab[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [7:0] an_of(input int i);
        logic [7:0] one = 8'h01;
        return ~(one << i);
    endfunction

    function automatic logic [6:0] pat_of(input int v);
        return (v == 16) ? 7'h7f : seg_tab[v];
    endfunction

    task automatic model_store(input int idx, input int v);
        m_shadow[idx*4 +: 4] = (v == 16) ? 4'h0 : 4'(v);
        m_bsh[idx]           = (v == 16);
    endtask

    task automatic model_start(input int v);
        model_store(0, v);
        m_next = 1;
        m_lock = 1;
    endtask

    task automatic model_capture(input logic [7:0] an, input logic [6:0] seg);
        int zeros = 0;
        int idx   = 0;
        int v;
        if (an == 8'hff) return;
        for (int i = 0; i < 8; i++) if (!an[i]) begin zeros++; idx = i; end
        if (zeros > 1) begin m_err[1] = 1; m_lock = 0; return; end
        v = seg_lookup(seg);
        if (v < 0) begin m_err[0] = 1; m_lock = 0; return; end
        if (!m_lock) begin
            if (idx == 0) model_start(v);
        end else if (idx == m_next) begin
            model_store(idx, v);
            if (idx == 7) begin
                m_num = m_shadow; m_blank = m_bsh; m_frames++; m_lock = 0;
            end else begin
                m_next++;
            end
        end else if (idx == m_next - 1) begin
            model_store(idx, v);
        end else begin
            m_err[2] = 1;
            m_lock   = 0;
            if (idx == 0) model_start(v);
        end
    endtask

    // One dwell of d cycles: a capture if the bus differs from the last dwell,
    // then a timeout if the dwell outlasts the limit measured from that capture.
    task automatic model_dwell(input logic [7:0] an, input logic [6:0] seg, input int d);
        bit captured = 0;
        if (!m_have_prev || an != m_pan || seg != m_pseg) begin
            model_capture(an, seg);
            captured = 1;
        end
        m_pan = an; m_pseg = seg; m_have_prev = 1;
        if (captured && m_lock && (d - (SETTLE + 2)) >= TMO) begin
            m_err[3] = 1;
            m_lock   = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".err"},    {28'b0, err_flags}, {28'b0, m_err});
        check({tag, ".locked"}, {31'b0, locked},    {31'b0, m_lock});
        check({tag, ".frames"}, fv_count,           m_frames);
        check({tag, ".num"},    dis_num,            m_num);
        check({tag, ".blank"},  {24'b0, blank_mask}, {24'b0, m_blank});
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic dwell(input logic [7:0] an, input logic [6:0] seg, input int d, input bit clr);
        disp_if.an_in  = an;
        disp_if.seg_in = seg;
        if (clr) begin
            err_clr = 1'b1;
            @(posedge clk); #1;
            err_clr = 1'b0;
            m_err   = '0;
            repeat (d - 1) @(posedge clk);
        end else begin
            repeat (d) @(posedge clk);
        end
        #1;
        model_dwell(an, seg, d);
        compare_all("dwell");
    endtask

    // err_clr asserted exactly on the capture edge of this dwell.
    task automatic dwell_clr_at_capture(input logic [7:0] an, input logic [6:0] seg, input int d);
        disp_if.an_in  = an;
        disp_if.seg_in = seg;
        repeat (SETTLE + 1) @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        repeat (d - SETTLE - 2) @(posedge clk);
        #1;
        m_err = '0;
        model_dwell(an, seg, d);
        compare_all("clrcap");
    endtask

    task automatic scan_value(input logic [31:0] v, input int start, input int n, input int d);
        for (int k = 0; k < n; k++) begin
            int i = (start + k) % 8;
            dwell(an_of(i), seg_tab[v[i*4 +: 4]], d, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dvals [8] = '{8, 7, 6, 5, 4, 16, 2, 1};
        int fv0, t0;

        disp_if.an_in  = 8'hff;
        disp_if.seg_in = 7'h7f;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst.num",    dis_num, 32'h0);
        check("rst.blank",  {24'b0, blank_mask}, 32'h0);
        check("rst.fv",     {31'b0, frame_valid}, 32'h0);
        check("rst.locked", {31'b0, locked}, 32'h0);
        check("rst.err",    {28'b0, err_flags}, 32'h0);

        // Free-running scan of 1234ABCD joined mid-scan at digit 3.
        t0 = cyc;
        scan_value(32'h1234ABCD, 3, 13, 10);
        check("scan.num",   dis_num, 32'h1234ABCD);
        check("scan.blank", {24'b0, blank_mask}, 32'h0);
        check("scan.err",   {28'b0, err_flags}, 32'h0);
        check("scan.within2", {31'b0, fv_count > 0 && (fv_cyc - t0) <= 2 * 8 * 10}, 32'h1);

        // Direct drive 8,7,6,5,4,blank,2,1 and measure frame_valid latency.
        fv0 = fv_count;
        for (int i = 0; i < 7; i++) dwell(an_of(i), pat_of(dvals[i]), 10, 0);
        t0 = cyc;
        dwell(an_of(7), pat_of(dvals[7]), 10, 0);
        check("direct.num",   dis_num, 32'h12045678);
        check("direct.blank", {24'b0, blank_mask}, 32'h20);
        check("direct.pulses", fv_count - fv0, 1);
        check("direct.latency", fv_cyc, t0 + SETTLE + 3);

        // Out-of-order digit, then recovery with a clean scan.
        fv0 = fv_count;
        dwell(an_of(0), seg_tab[0], 10, 0);
        dwell(an_of(1), seg_tab[1], 10, 0);
        dwell(an_of(3), seg_tab[3], 10, 0);
        check("order.err",    {28'b0, err_flags}, 32'h4);
        check("order.locked", {31'b0, locked}, 32'h0);
        check("order.nofv",   fv_count - fv0, 0);
        scan_value(32'h9E0F_C3A7, 0, 8, 10);
        check("recover.num", dis_num, 32'h9E0F_C3A7);

        // Bad segment, multiple enables, clear colliding with a new error.
        dwell(8'hff, 7'h7f, 10, 1);
        check("clr.err", {28'b0, err_flags}, 32'h0);
        dwell(an_of(2), 7'h55, 10, 0);
        check("seg.err", {28'b0, err_flags}, 32'h1);
        dwell(8'hfc, 7'h01, 10, 0);
        check("an.err",  {28'b0, err_flags}, 32'h3);
        dwell_clr_at_capture(8'hf5, 7'h01, 12);
        check("clrcap.err", {28'b0, err_flags}, 32'h2);

        // Timeout: four digits then a long blank stretch.
        dwell(an_of(0), seg_tab[5], 10, 1);
        for (int i = 1; i < 4; i++) dwell(an_of(i), seg_tab[i], 10, 0);
        check("tmo.locked_before", {31'b0, locked}, 32'h1);
        dwell(8'hff, 7'h7f, 75, 0);
        check("tmo.err",    {28'b0, err_flags}, 32'h8);
        check("tmo.locked", {31'b0, locked}, 32'h0);

        // Reset in the middle of digit 5.
        for (int i = 0; i < 5; i++) dwell(an_of(i), seg_tab[i + 8], 10, 0);
        disp_if.an_in  = an_of(5);
        disp_if.seg_in = seg_tab[13];
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check("mrst.num",    dis_num, 32'h0);
        check("mrst.blank",  {24'b0, blank_mask}, 32'h0);
        check("mrst.locked", {31'b0, locked}, 32'h0);
        check("mrst.err",    {28'b0, err_flags}, 32'h0);
        fv0 = fv_count;
        dwell(an_of(5), seg_tab[13], 10, 0);
        dwell(an_of(6), seg_tab[14], 10, 0);
        dwell(an_of(7), seg_tab[15], 10, 0);
        check("mrst.nofv", fv_count - fv0, 0);
        scan_value(32'h0BADF00D, 0, 8, 10);
        check("mrst.num2", dis_num, 32'h0BADF00D);

        // Randomized scans with injected faults and occasional clears.
        for (int f = 0; f < 40; f++) begin
            logic [31:0] v     = $urandom;
            logic [7:0]  bmask = 8'($urandom) & 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                int          kind = $urandom_range(0, 19);
                int          d    = $urandom_range(8, 16);
                bit          clr  = ($urandom_range(0, 15) == 0);
                logic [6:0]  p    = bmask[i] ? 7'h7f : seg_tab[v[i*4 +: 4]];
                logic [6:0]  bad;
                logic [7:0]  two;
                case (kind)
                    0: continue;
                    1: begin
                        do bad = 7'($urandom); while (seg_lookup(bad) >= 0);
                        dwell(an_of(i), bad, d, clr);
                        continue;
                    end
                    2: begin
                        two = an_of(i) & an_of((i + 1 + $urandom_range(0, 6)) % 8);
                        dwell(two, p, d, clr);
                        continue;
                    end
                    3: dwell(8'hff, 7'h7f, d, clr);
                    4: dwell(an_of(i), seg_tab[$urandom_range(0, 15)], d, clr);
                    default: ;
                endcase
                dwell(an_of(i), p, $urandom_range(8, 16), 0);
            end
        end
        compare_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
